// File: rtl/renode_pkg.sv
// Shared types for the Renode bus arbiter: bus field types,
// access-size encoding and the arbiter FSM states.
package renode_pkg;

    typedef logic [31:0] address_t;
    typedef logic [63:0] data_t;

    typedef enum logic [2:0] {
        Byte       = 3'd0,
        Word       = 3'd1,
        DoubleWord = 3'd2,
        QuadWord   = 3'd3
    } valid_bits_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RSP,
        RESPOND
    } arbiter_state_e;

    function automatic logic is_legal_bits(valid_bits_e b);
        return b inside {Byte, Word, DoubleWord, QuadWord};
    endfunction

endpackage

// File: rtl/renode_rr_picker.sv
// Round-robin picker: first set request at or after the pointer,
// searching upward with wrap-around.
module renode_rr_picker #(
    parameter int N    = 2,
    parameter int IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    i_req,
    input  logic [IdxW-1:0] i_ptr,
    output logic [N-1:0]    o_grant,
    output logic [IdxW-1:0] o_idx,
    output logic            o_found
);

    localparam int SW = IdxW + 1;

    logic [N-1:0]  w_rot;
    logic [SW-1:0] w_sum;

    always_comb begin
        w_rot = N'({i_req, i_req} >> i_ptr);
        w_sum = '0;
        // descending scan so the lowest rotated position wins
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_sum = {1'b0, i_ptr} + SW'(k);
            end
        end
        if (w_sum >= SW'(N)) begin
            w_sum = w_sum - SW'(N);
        end
        o_idx   = w_sum[IdxW-1:0];
        o_found = |i_req;
        o_grant = o_found ? (N'(1) << o_idx) : '0;
    end

endmodule

// File: rtl/renode_bus_arbiter.sv
// Shares one Renode transaction channel among several HDL requesters,
// one outstanding transaction at a time, with response timeout.
module renode_bus_arbiter
    import renode_pkg::*;
#(
    parameter int RequestersCount = 2,
    parameter int TimeoutCycles   = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [RequestersCount-1:0] req_valid,
    output logic [RequestersCount-1:0] req_ready,
    input  logic [RequestersCount-1:0] req_write,
    input  address_t                   req_address [RequestersCount],
    input  data_t                      req_data [RequestersCount],
    input  valid_bits_e                req_data_bits [RequestersCount],
    output logic [RequestersCount-1:0] rsp_valid,
    output data_t                      rsp_data,
    output logic                       rsp_error,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_write,
    output address_t                   out_address,
    output data_t                      out_data,
    output valid_bits_e                out_data_bits,
    input  logic                       in_valid,
    input  data_t                      in_data,
    input  logic                       in_error,
    output logic                       busy
);

    localparam int IdxW = (RequestersCount > 1) ? $clog2(RequestersCount) : 1;
    localparam int CntW = $clog2(TimeoutCycles) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(RequestersCount - 1);

    arbiter_state_e r_state;
    arbiter_state_e w_next;

    logic [IdxW-1:0]            r_rr_ptr;
    logic [IdxW-1:0]            r_grant_idx;
    logic [IdxW-1:0]            w_ptr_next;
    logic [IdxW-1:0]            w_pick_idx;
    logic [RequestersCount-1:0] w_pick_grant;
    logic                       w_pick_found;
    logic                       w_pick_legal;

    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_inc;
    logic            w_timeout;

    logic        r_write;
    address_t    r_address;
    data_t       r_data;
    valid_bits_e r_bits;
    data_t       r_rsp_data;
    logic        r_rsp_error;

    renode_rr_picker #(
        .N    (RequestersCount),
        .IdxW (IdxW)
    ) u_picker (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_found (w_pick_found)
    );

    assign w_pick_legal = is_legal_bits(req_data_bits[w_pick_idx]);
    assign w_ptr_next   = (r_grant_idx == IdxLast) ? '0 : r_grant_idx + 1'b1;
    assign w_cnt_inc    = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
    // the cycle whose increment would land on TimeoutCycles-1 is the last wait cycle
    assign w_timeout    = (w_cnt_inc == CntLast);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_pick_found) begin
                    w_next = w_pick_legal ? ISSUE : RESPOND;
                end
            end
            ISSUE: begin
                if (out_ready) begin
                    w_next = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (in_valid || w_timeout) begin
                    w_next = RESPOND;
                end
            end
            RESPOND: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (rst_n && r_state == IDLE) begin
            req_ready = w_pick_grant;
        end
        if (rst_n && r_state == RESPOND) begin
            rsp_valid = RequestersCount'(1) << r_grant_idx;
        end
    end

    assign out_valid     = (r_state == ISSUE);
    assign busy          = (r_state != IDLE);
    assign out_write     = r_write;
    assign out_address   = r_address;
    assign out_data      = r_data;
    assign out_data_bits = r_bits;
    assign rsp_data      = r_rsp_data;
    assign rsp_error     = r_rsp_error;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_grant_idx <= '0;
            r_cnt       <= '0;
            r_write     <= 1'b0;
            r_address   <= '0;
            r_data      <= '0;
            r_bits      <= Byte;
            r_rsp_data  <= '0;
            r_rsp_error <= 1'b0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                IDLE: begin
                    if (w_pick_found) begin
                        r_grant_idx <= w_pick_idx;
                        r_write     <= req_write[w_pick_idx];
                        r_address   <= req_address[w_pick_idx];
                        r_data      <= req_data[w_pick_idx];
                        r_bits      <= req_data_bits[w_pick_idx];
                        r_rsp_data  <= '0;
                        r_rsp_error <= !w_pick_legal;
                    end
                end
                ISSUE: begin
                    if (out_ready) begin
                        r_cnt <= '0;
                    end
                end
                WAIT_RSP: begin
                    if (in_valid) begin
                        r_rsp_data  <= in_data;
                        r_rsp_error <= in_error;
                    end else if (w_timeout) begin
                        r_rsp_data  <= '0;
                        r_rsp_error <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                RESPOND: r_rr_ptr <= w_ptr_next;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_renode_bus_arbiter.sv
// Scenario bench for renode_bus_arbiter: three requesters, short
// timeout, expected responses queued at grant and popped at rsp_valid.
module tb_renode_bus_arbiter;
    import renode_pkg::*;

    localparam int N  = 3;
    localparam int TC = 8;

    typedef struct {
        int    idx;
        logic  err;
        data_t data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [N-1:0] req_valid;
    logic [N-1:0] req_ready;
    logic [N-1:0] req_write;
    address_t    req_address [N];
    data_t       req_data [N];
    valid_bits_e req_data_bits [N];
    logic [N-1:0] rsp_valid;
    data_t       rsp_data;
    logic        rsp_error;
    logic        out_valid;
    logic        out_ready;
    logic        out_write;
    address_t    out_address;
    data_t       out_data;
    valid_bits_e out_data_bits;
    logic        in_valid;
    data_t       in_data;
    logic        in_error;
    logic        busy;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    renode_bus_arbiter #(
        .RequestersCount (N),
        .TimeoutCycles   (TC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_address   (req_address),
        .req_data      (req_data),
        .req_data_bits (req_data_bits),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_error     (rsp_error),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_write     (out_write),
        .out_address   (out_address),
        .out_data      (out_data),
        .out_data_bits (out_data_bits),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_error      (in_error),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input int idx, input logic err, input data_t data);
        exp_t e;
        e.idx  = idx;
        e.err  = err;
        e.data = data;
        return e;
    endfunction

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v = N'(1) << i;
        return v;
    endfunction

    task automatic wait_rsp(input int budget, output int lat, output bit got);
        got = 1'b0;
        lat = 0;
        while (!got && lat < budget) begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
            #1;
            got = (rsp_valid != '0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '1;
        req_write = '1;
        for (int i = 0; i < N; i++) begin
            req_address[i] = 32'hA000 + 32'(i);
            req_data[i] = 64'h55;
            req_data_bits[i] = Word;
        end
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 64'h99;
        in_error = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset_req_ready got=%b want=000", req_ready); end
        n_checks++; if (rsp_valid !== '0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b want=000", rsp_valid); end
        n_checks++; if (rsp_error !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_error got=%b want=0", rsp_error); end
        n_checks++; if (rsp_data !== '0) begin n_fail++; $display("FAIL reset_rsp_data got=%h want=0", rsp_data); end
        n_checks++; if (out_address !== '0) begin n_fail++; $display("FAIL reset_out_address got=%h want=0", out_address); end
        n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got=%h want=0", out_data); end
        n_checks++; if (out_write !== 1'b0) begin n_fail++; $display("FAIL reset_out_write got=%b want=0", out_write); end
        n_checks++; if (out_data_bits !== Byte) begin n_fail++; $display("FAIL reset_out_bits got=%0d want=0", out_data_bits); end
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = '0;
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_single();
        exp_t e;
        int lat;
        bit got;
        @(negedge clk);
        req_valid = 3'b001;
        req_write = 3'b001;
        req_address[0] = 32'h1000;
        req_data[0] = 64'hDEAD;
        req_data_bits[0] = DoubleWord;
        out_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL single_ready got=%b want=001", req_ready); end
        sb.push_back(mk(0, 1'b0, 64'h0123_4567_89AB_CDEF));
        @(negedge clk);
        req_valid = '0;
        req_address[0] = 32'h5555;
        #1;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_out_valid got=%b want=1", out_valid); end
        n_checks++; if (out_address !== 32'h1000) begin n_fail++; $display("FAIL single_out_address got=%h want=1000", out_address); end
        n_checks++; if (out_data !== 64'hDEAD) begin n_fail++; $display("FAIL single_out_data got=%h want=dead", out_data); end
        n_checks++; if (out_write !== 1'b1) begin n_fail++; $display("FAIL single_out_write got=%b want=1", out_write); end
        n_checks++; if (out_data_bits !== DoubleWord) begin n_fail++; $display("FAIL single_out_bits got=%0d want=2", out_data_bits); end
        @(negedge clk);
        in_valid = 1'b1;
        in_data = 64'h0123_4567_89AB_CDEF;
        in_error = 1'b0;
        #1;
        wait_rsp(10, lat, got);
        lat += 2;
        e = sb.pop_front();
        n_checks++; if (!got || lat != 3) begin n_fail++; $display("FAIL single_latency got=%0d want=3", lat); end
        n_checks++; if (rsp_valid !== oh(e.idx)) begin n_fail++; $display("FAIL single_rsp_valid got=%b want=%b", rsp_valid, oh(e.idx)); end
        n_checks++; if (rsp_error !== e.err) begin n_fail++; $display("FAIL single_rsp_error got=%b want=%b", rsp_error, e.err); end
        n_checks++; if (rsp_data !== e.data) begin n_fail++; $display("FAIL single_rsp_data got=%h want=%h", rsp_data, e.data); end
    endtask

    task automatic test_fairness();
        exp_t e;
        int lat;
        int w;
        bit got;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 3'b111;
        for (int i = 0; i < N; i++) begin
            req_address[i] = 32'h100 * 32'(i);
            req_data_bits[i] = Word;
        end
        out_ready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            w = 0;
            #1;
            while (req_ready == '0 && w < 4) begin
                @(negedge clk);
                #1;
                w++;
            end
            n_checks++; if (req_ready !== oh(t % N)) begin n_fail++; $display("FAIL fair_grant_%0d got=%b want=%b", t, req_ready, oh(t % N)); end
            sb.push_back(mk(t % N, 1'b0, 64'hA0 + 64'(t)));
            @(negedge clk);
            @(negedge clk);
            in_valid = 1'b1;
            in_data = 64'hA0 + 64'(t);
            in_error = 1'b0;
            wait_rsp(5, lat, got);
            e = sb.pop_front();
            n_checks++; if (rsp_valid !== oh(e.idx)) begin n_fail++; $display("FAIL fair_rsp_valid_%0d got=%b want=%b", t, rsp_valid, oh(e.idx)); end
            n_checks++; if (rsp_data !== e.data) begin n_fail++; $display("FAIL fair_rsp_data_%0d got=%h want=%h", t, rsp_data, e.data); end
        end
        req_valid = '0;
    endtask

    task automatic test_timeout();
        exp_t e;
        int lat;
        bit got;
        @(negedge clk);
        req_valid = 3'b010;
        req_write[1] = 1'b0;
        req_address[1] = 32'h2000;
        req_data_bits[1] = Word;
        out_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL tmo_ready got=%b want=010", req_ready); end
        sb.push_back(mk(1, 1'b1, 64'h0));
        @(negedge clk);
        req_valid = '0;
        #1;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL tmo_out_valid got=%b want=1", out_valid); end
        wait_rsp(20, lat, got);
        e = sb.pop_front();
        n_checks++; if (!got || lat != TC) begin n_fail++; $display("FAIL tmo_latency got=%0d want=%0d", lat, TC); end
        n_checks++; if (rsp_valid !== oh(e.idx)) begin n_fail++; $display("FAIL tmo_rsp_valid got=%b want=%b", rsp_valid, oh(e.idx)); end
        n_checks++; if (rsp_error !== e.err) begin n_fail++; $display("FAIL tmo_rsp_error got=%b want=%b", rsp_error, e.err); end
        n_checks++; if (rsp_data !== e.data) begin n_fail++; $display("FAIL tmo_rsp_data got=%h want=%h", rsp_data, e.data); end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int lat;
        bit got;
        @(negedge clk);
        req_valid = 3'b001;
        req_data_bits[0] = Word;
        out_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL rstmid_wrap_grant got=%b want=001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1;
        in_data = 64'hFFFF;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        n_checks++; if (rsp_valid !== '0) begin n_fail++; $display("FAIL rstmid_rsp_valid got=%b want=000", rsp_valid); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            n_checks++; if (rsp_valid !== '0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_quiet_%0d got=%b/%b want=000/0", c, rsp_valid, busy); end
        end
        req_valid = 3'b111;
        #1;
        n_checks++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL rstmid_ptr got=%b want=001", req_ready); end
        sb.push_back(mk(0, 1'b0, 64'h4242));
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data = 64'h4242;
        in_error = 1'b0;
        wait_rsp(5, lat, got);
        e = sb.pop_front();
        n_checks++; if (rsp_valid !== oh(e.idx)) begin n_fail++; $display("FAIL rstmid_rsp_valid2 got=%b want=%b", rsp_valid, oh(e.idx)); end
        n_checks++; if (rsp_data !== e.data) begin n_fail++; $display("FAIL rstmid_rsp_data got=%h want=%h", rsp_data, e.data); end
    endtask

    task automatic test_back_pressure();
        exp_t e;
        int lat;
        bit got;
        @(negedge clk);
        req_valid = 3'b101;
        req_write[2] = 1'b1;
        req_address[2] = 32'h3000;
        req_data[2] = 64'hBEEF_0000_1111;
        req_data_bits[2] = QuadWord;
        out_ready = 1'b0;
        #1;
        n_checks++; if (req_ready !== 3'b100) begin n_fail++; $display("FAIL bp_ready got=%b want=100", req_ready); end
        sb.push_back(mk(2, 1'b1, 64'h77));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            req_valid = '0;
            req_address[2] = 32'h3000 + 32'(c + 1);
            req_data[2] = ~req_data[2];
            #1;
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_%0d got=%b want=1", c, out_valid); end
            n_checks++; if (out_address !== 32'h3000) begin n_fail++; $display("FAIL bp_addr_%0d got=%h want=3000", c, out_address); end
            n_checks++; if (out_data !== 64'hBEEF_0000_1111) begin n_fail++; $display("FAIL bp_data_%0d got=%h want=beef00001111", c, out_data); end
            n_checks++; if (out_data_bits !== QuadWord) begin n_fail++; $display("FAIL bp_bits_%0d got=%0d want=3", c, out_data_bits); end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_release got=%b want=1", out_valid); end
        @(negedge clk);
        in_valid = 1'b1;
        in_data = 64'h77;
        in_error = 1'b1;
        wait_rsp(5, lat, got);
        e = sb.pop_front();
        n_checks++; if (rsp_valid !== oh(e.idx)) begin n_fail++; $display("FAIL bp_rsp_valid got=%b want=%b", rsp_valid, oh(e.idx)); end
        n_checks++; if (rsp_error !== e.err) begin n_fail++; $display("FAIL bp_rsp_error got=%b want=%b", rsp_error, e.err); end
        n_checks++; if (rsp_data !== e.data) begin n_fail++; $display("FAIL bp_rsp_data got=%h want=%h", rsp_data, e.data); end
        in_error = 1'b0;
    endtask

    task automatic test_bad_size_race();
        exp_t e;
        int lat;
        bit got;
        @(negedge clk);
        req_valid = 3'b001;
        req_data_bits[0] = valid_bits_e'(3'd5);
        out_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL bad_ready got=%b want=001", req_ready); end
        sb.push_back(mk(0, 1'b1, 64'h0));
        got = 1'b0;
        lat = 0;
        while (!got && lat < 4) begin
            @(negedge clk);
            req_valid = '0;
            lat++;
            #1;
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bad_out_valid_%0d got=%b want=0", lat, out_valid); end
            got = (rsp_valid != '0);
        end
        e = sb.pop_front();
        n_checks++; if (!got || lat != 1) begin n_fail++; $display("FAIL bad_latency got=%0d want=1", lat); end
        n_checks++; if (rsp_valid !== oh(e.idx)) begin n_fail++; $display("FAIL bad_rsp_valid got=%b want=%b", rsp_valid, oh(e.idx)); end
        n_checks++; if (rsp_error !== e.err) begin n_fail++; $display("FAIL bad_rsp_error got=%b want=%b", rsp_error, e.err); end
        n_checks++; if (rsp_data !== e.data) begin n_fail++; $display("FAIL bad_rsp_data got=%h want=%h", rsp_data, e.data); end
        @(negedge clk);
        req_valid = 3'b010;
        req_data_bits[1] = Byte;
        #1;
        n_checks++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL race_ready got=%b want=010", req_ready); end
        sb.push_back(mk(1, 1'b0, 64'hCAFE));
        @(negedge clk);
        req_valid = '0;
        for (int k = 0; k < TC - 2; k++) begin
            @(negedge clk);
            #1;
            n_checks++; if (rsp_valid !== '0) begin n_fail++; $display("FAIL race_early_%0d got=%b want=000", k, rsp_valid); end
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data = 64'hCAFE;
        in_error = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        e = sb.pop_front();
        n_checks++; if (rsp_valid !== oh(e.idx)) begin n_fail++; $display("FAIL race_rsp_valid got=%b want=%b", rsp_valid, oh(e.idx)); end
        n_checks++; if (rsp_error !== e.err) begin n_fail++; $display("FAIL race_rsp_error got=%b want=%b", rsp_error, e.err); end
        n_checks++; if (rsp_data !== e.data) begin n_fail++; $display("FAIL race_rsp_data got=%h want=%h", rsp_data, e.data); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_timeout();
        test_reset_mid();
        test_back_pressure();
        test_bad_size_race();
        repeat (2) @(negedge clk);
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_left got=%0d want=0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
